// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared AXI constants, AR state type and request struct for the DMA engines
package dma_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
    localparam int         DMA_ADDR_WIDTH  = 64;

    typedef enum logic {
        AR_IDLE,
        AR_VALID
    } ar_state_t;

    typedef struct packed {
        logic [DMA_ADDR_WIDTH-1:0] addr;
        logic [7:0]                len;
    } dma_req_t;

    function automatic logic [2:0] axi_size(input int data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - show-ahead synchronous FIFO; head is valid while !empty, push and pop may coincide at any level
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;

    assign empty  = (count == '0);
    assign full   = (count == (AW+1)'(DEPTH));
    assign do_pop = pop && !empty;
    // Head reads as zero when empty so the unwritten array never leaks out.
    assign head   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/dma_rd_engine.sv
// rtl/dma_rd_engine.sv - AXI4 read master with credit-reserved beat FIFO; DMA_RD_ENGINE_PERF_EN adds perf counters
module dma_rd_engine
    import dma_pkg::*;
#(
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 512,
    parameter int ID_WIDTH        = 4,
    parameter int FIFO_DEPTH      = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dma_rd_req,
    input  logic [ADDR_WIDTH-1:0] dma_rd_addr,
    input  logic [7:0]            dma_rd_len,
    output logic                  dma_rd_req_ack,
    output logic [DATA_WIDTH-1:0] dma_rd_data,
    output logic                  dma_rd_data_valid,
    input  logic                  dma_rd_data_taken,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    output logic                  rd_error,
    output logic                  busy
`ifdef DMA_RD_ENGINE_PERF_EN
    ,
    output logic [31:0]           perf_rd_beats,
    output logic [31:0]           perf_stall_cycles,
    output logic [31:0]           perf_ar_wait
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int XW = (CW > 9) ? CW : 9;

    ar_state_t     state;
    dma_req_t      ar_q;
    logic [CW-1:0] credits;
    logic [OW-1:0] outstanding;
    logic          rready_q;
    logic          ack_q;
    logic          arvalid_q;
    logic          error_q;
    logic          accept;
    logic          beat_ok;
    logic          burst_done;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    // Credits already cover every beat of every issued burst, so acceptance only checks the registered count.
    assign accept     = (state == AR_IDLE) && dma_rd_req
                        && (XW'(credits) >= XW'(dma_rd_len) + XW'(1))
                        && (outstanding < OW'(MAX_OUTSTANDING));
    // Beats with nothing outstanding are stragglers from before a reset and are dropped.
    assign beat_ok    = m_axi_rvalid && rready_q && (outstanding != '0);
    assign burst_done = beat_ok && m_axi_rlast;
    assign fifo_pop   = !fifo_empty && dma_rd_data_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= AR_IDLE;
            ar_q        <= '0;
            ack_q       <= 1'b0;
            arvalid_q   <= 1'b0;
            credits     <= CW'(FIFO_DEPTH);
            outstanding <= '0;
            rready_q    <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            rready_q <= 1'b1;
            ack_q    <= 1'b0;
            case (state)
                AR_IDLE: begin
                    if (accept) begin
                        ar_q.addr <= DMA_ADDR_WIDTH'(dma_rd_addr);
                        ar_q.len  <= dma_rd_len;
                        ack_q     <= 1'b1;
                        arvalid_q <= 1'b1;
                        state     <= AR_VALID;
                    end
                end
                AR_VALID: begin
                    if (m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        state     <= AR_IDLE;
                    end
                end
                default: state <= AR_IDLE;
            endcase
            credits     <= credits + CW'(fifo_pop)
                           - (accept ? CW'(dma_rd_len) + CW'(1) : CW'(0));
            outstanding <= outstanding + OW'(accept) - OW'(burst_done);
            if (beat_ok && (m_axi_rresp != AXI_RESP_OKAY)) begin
                error_q <= 1'b1;
            end
        end
    end

    sync_fifo_fwft #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (beat_ok),
        .push_data (m_axi_rdata),
        .pop       (fifo_pop),
        .head      (dma_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assert property (@(posedge clk) disable iff (rst) !(beat_ok && fifo_full));

    assign dma_rd_req_ack    = ack_q;
    assign dma_rd_data_valid = !fifo_empty;
    assign m_axi_arvalid     = arvalid_q;
    assign m_axi_araddr      = ar_q.addr[ADDR_WIDTH-1:0];
    assign m_axi_arlen       = ar_q.len;
    assign m_axi_arsize      = axi_size(DATA_WIDTH);
    assign m_axi_arburst     = AXI_BURST_INCR;
    assign m_axi_arid        = '0;
    assign m_axi_rready      = rready_q;
    assign rd_error          = error_q;
    assign busy              = (outstanding != '0) || (fifo_count != '0) || (state == AR_VALID);

`ifdef DMA_RD_ENGINE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_rd_beats     <= '0;
            perf_stall_cycles <= '0;
            perf_ar_wait      <= '0;
        end else begin
            if (m_axi_rvalid && rready_q && (perf_rd_beats != '1)) begin
                perf_rd_beats <= perf_rd_beats + 32'd1;
            end
            if (!fifo_empty && !dma_rd_data_taken && (perf_stall_cycles != '1)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if ((state == AR_VALID) && !m_axi_arready && (perf_ar_wait != '1)) begin
                perf_ar_wait <= perf_ar_wait + 32'd1;
            end
        end
    end
`endif

endmodule
